if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, which is the instruction word driven on InstrD for a bubble.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port StallF, input, 1 bit, from the hazard unit; it inhibits issue of a new fetch.
REQ-006 SHALL have port StallD, input, 1 bit, from the hazard unit; it holds the IF/ID outputs.
REQ-007 SHALL have port PCSrcD, input, 1 bit, meaning a branch is taken in decode.
REQ-008 SHALL have port PCBranchD, input, 32 bits, the branch target.
REQ-009 SHALL have port JumpD, input, 1 bit, meaning a jump is in decode.
REQ-010 SHALL have port PCJumpD, input, 32 bits, the jump target.
REQ-011 SHALL have port imem_req, output, 1 bit, a one-cycle fetch request pulse.
REQ-012 SHALL have port imem_addr, output, 32 bits, the fetch address; it equals the PC.
REQ-013 SHALL have port imem_valid, input, 1 bit, the response strobe; it arrives 1 or more cycles after imem_req.
REQ-014 SHALL have port imem_rdata, input, 32 bits, the instruction word, qualified by imem_valid.
REQ-015 SHALL have port InstrD, output, 32 bits, the IF/ID instruction.
REQ-016 SHALL have port PCPlus4D, output, 32 bits, the IF/ID copy of PC+4.
REQ-017 SHALL have port ValidD, output, 1 bit, meaning the IF/ID entry holds a real instruction.
REQ-018 SHALL have port ImemStallF, output, 1 bit, meaning fetch is waiting on memory; it is ORed into StallF externally.

Function
REQ-019 SHALL implement a 4-state FSM: REQ (issue), WAIT (one request outstanding), DISCARD (drop the stale response), BUF (response held while decode is stalled).
REQ-020 In REQ with StallF=0, SHALL assert imem_req with imem_addr=PC and go to WAIT; with StallF=1, SHALL stay in REQ with imem_req=0.
REQ-021 In WAIT with imem_valid=1 and StallD=0, SHALL load InstrD=imem_rdata, PCPlus4D=PC+4, ValidD=1, set PC=PC+4, and go to REQ.
REQ-022 In WAIT with imem_valid=1 and StallD=1, SHALL capture imem_rdata in a 1-entry buffer, leave IF/ID unchanged, and go to BUF.
REQ-023 In BUF with StallD=0, SHALL move the buffer into IF/ID, set PC=PC+4, and go to REQ.
REQ-024 Whenever StallD=0 and no instruction is delivered that cycle, SHALL load InstrD=NOP_INSTR and ValidD=0.
REQ-025 While StallD=1, SHALL hold InstrD, PCPlus4D and ValidD unchanged.
REQ-026 Redirect is (PCSrcD|JumpD)&!StallD; PCSrcD wins if both are set; the target is PCBranchD or PCJumpD respectively.
REQ-027 On redirect, SHALL set PC=target and flush IF/ID (InstrD=NOP_INSTR, ValidD=0).
REQ-028 Redirect state rules:
- from WAIT without imem_valid: go to DISCARD;
- from WAIT with imem_valid: drop the response and go to REQ;
- from BUF: drop the buffer and go to REQ;
- from REQ: a request issued that same cycle is for the old PC, so go to DISCARD.
REQ-029 In DISCARD, SHALL ignore imem_rdata, leave the PC alone, and go to REQ on imem_valid.
REQ-030 SHALL assert ImemStallF=1 in WAIT when imem_valid=0, and always in DISCARD; otherwise ImemStallF=0.
REQ-031 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 without error.
REQ-032 SHALL have at most one outstanding request; imem_valid outside WAIT/DISCARD is ignored.

Reset
REQ-033 rst_n low SHALL immediately set PC=RESET_PC, state=REQ, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, imem_req=0, and clear the buffer.
REQ-034 Reset asserted while a request is outstanding SHALL abandon it; a late imem_valid arriving after reset deasserts (state REQ) SHALL be ignored.
REQ-035 The first imem_req SHALL occur in the first clock edge after rst_n deasserts, with StallF=0.

Structure
REQ-036 Package mips_pkg SHALL hold RESET_PC_DEFAULT, NOP_INSTR, and the fetch-state enum; it is shared with the decode stage.
REQ-037 SHALL instantiate one sub-module, ifid_reg: a 64-bit register plus valid bit, with enable (!StallD) and synchronous clear (flush), reset by rst_n.

Verification
REQ-038 Reset, then 1-cycle memory latency, no stalls -> imem_addr 0,4,8 on alternate cycles; PCPlus4D 4,8,12; ValidD=1.
REQ-039 Latency 3 -> ImemStallF=1 for 2 cycles per fetch; InstrD updates once per fetch.
REQ-040 imem_valid with StallD=1 for 2 cycles -> InstrD held; buffered word appears the cycle after StallD drops; no fetch lost.
REQ-041 PCSrcD=1, PCBranchD=32'h100 while WAIT, before response -> DISCARD; stale word dropped; next imem_addr=32'h100; ValidD=0 for the flush.
REQ-042 JumpD=1 and PCSrcD=1 together -> PCBranchD taken; PCSrcD with StallD=1 -> ignored.
REQ-043 rst_n pulsed low mid-WAIT, late imem_valid after release -> ignored; first request is to RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: reset constants and the
// fetch-state encoding used by the IF stage and referenced by decode.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ     = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2,
        FETCH_BUF     = 2'd3
    } fetch_state_e;

    // Sequential PC step; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_step(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction and PC+4 plus a valid bit, with
// load enable and a synchronous flush that has priority over the enable.
module ifid_reg #(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] instr_in,
    input  logic [31:0] pcp4_in,
    input  logic        valid_in,
    output logic [31:0] instr_out,
    output logic [31:0] pcp4_out,
    output logic        valid_out
);

    logic [63:0] data_q, data_d;
    logic        valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr) begin
            data_d  = {NOP_INSTR, 32'h0000_0000};
            valid_d = 1'b0;
        end else if (en) begin
            data_d  = {instr_in, pcp4_in};
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {NOP_INSTR, 32'h0000_0000};
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = data_q[63:32];
    assign pcp4_out  = data_q[31:0];
    assign valid_out = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM against a
// variable-latency instruction memory, feeding the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        ImemStallF
);

    import mips_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_pcp4;
    logic         ifid_valid;

    assign redirect  = (PCSrcD | JumpD) & ~StallD;
    assign target    = PCSrcD ? PCBranchD : PCJumpD;
    assign pc_plus4  = pc_step(pc_q);
    assign imem_addr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        imem_req   = 1'b0;
        ImemStallF = 1'b0;
        ifid_instr = NOP_INSTR;
        ifid_pcp4  = 32'h0000_0000;
        ifid_valid = 1'b0;

        unique case (state_q)
            FETCH_REQ: begin
                if (!StallF && rst_n) begin
                    imem_req = 1'b1;
                    state_d  = FETCH_WAIT;
                end
                // A request leaving this cycle targets the old PC and must be drained.
                if (redirect) begin
                    state_d = imem_req ? FETCH_DISCARD : FETCH_REQ;
                end
            end
            FETCH_WAIT: begin
                if (imem_valid) begin
                    if (redirect) begin
                        state_d = FETCH_REQ;
                    end else if (!StallD) begin
                        ifid_instr = imem_rdata;
                        ifid_pcp4  = pc_plus4;
                        ifid_valid = 1'b1;
                        pc_d       = pc_plus4;
                        state_d    = FETCH_REQ;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = FETCH_BUF;
                    end
                end else begin
                    ImemStallF = 1'b1;
                    if (redirect) begin
                        state_d = FETCH_DISCARD;
                    end
                end
            end
            FETCH_BUF: begin
                if (redirect) begin
                    state_d = FETCH_REQ;
                end else if (!StallD) begin
                    ifid_instr = buf_q;
                    ifid_pcp4  = pc_plus4;
                    ifid_valid = 1'b1;
                    pc_d       = pc_plus4;
                    state_d    = FETCH_REQ;
                end
            end
            FETCH_DISCARD: begin
                ImemStallF = 1'b1;
                if (imem_valid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        if (redirect) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (~StallD),
        .clr       (redirect),
        .instr_in  (ifid_instr),
        .pcp4_in   (ifid_pcp4),
        .valid_in  (ifid_valid),
        .instr_out (InstrD),
        .pcp4_out  (PCPlus4D),
        .valid_out (ValidD)
    );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a program-order fetch model pushes expected
// IF/ID contents per issued fetch; a monitor pops them as ValidD presents.
module tb_if_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        JumpD;
    logic [31:0] PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        ImemStallF;

    int          n_compared = 0;
    int          n_mismatched = 0;
    int          n_deliv = 0;

    exp_t        expQ[$];
    logic [31:0] next_pc = TB_RESET_PC;
    bit          mem_busy = 1'b0;
    bit          mem_stale = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    int          late_cnt = -1;

    bit          edge_stalld = 1'b0;
    bit          edge_redirect = 1'b0;
    bit          model_valid = 1'b0;
    logic [31:0] model_instr = TB_NOP;
    logic [31:0] model_pcp4 = '0;

    if_stage #(
        .RESET_PC  (TB_RESET_PC),
        .NOP_INSTR (TB_NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .ImemStallF (ImemStallF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    function automatic logic [31:0] pickTarget();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0100;
            1:       return 32'hFFFF_FFF8;
            default: return {r[31:2], 2'b00};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, plays the memory, and
    // advances the program-order model for the upcoming rising edge.
    task automatic applyStimulus(input bit rst_in, input bit sf, input bit sd,
                                 input bit br, input bit jp,
                                 input logic [31:0] bt, input logic [31:0] jt,
                                 input int lat, output bit req_seen);
        bit respond;
        bit redirect;
        @(negedge clk);
        rst_n     = ~rst_in;
        StallF    = sf;
        StallD    = sd;
        PCSrcD    = br;
        JumpD     = jp;
        PCBranchD = bt;
        PCJumpD   = jt;
        respond    = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                respond    = 1'b1;
                imem_valid = 1'b1;
                imem_rdata = memWord(mem_addr);
            end else begin
                mem_cnt--;
            end
        end else if (late_cnt >= 0) begin
            if (late_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end
            late_cnt--;
        end
        #1;
        req_seen = imem_req;
        if (rst_in) begin
            checkOutput("rst_imem_req", imem_req, 1'b0);
            checkOutput("rst_imem_stall", ImemStallF, 1'b0);
            expQ.delete();
            next_pc = TB_RESET_PC;
            if (mem_busy) begin
                late_cnt = mem_cnt;
                mem_busy = 1'b0;
            end
            edge_stalld   = 1'b0;
            edge_redirect = 1'b0;
            return;
        end
        redirect = (br | jp) & ~sd;
        checkOutput("imem_stall", ImemStallF, mem_busy && (!respond || mem_stale));
        if (respond) mem_busy = 1'b0;
        if (imem_req) begin
            checkOutput("imem_addr", imem_addr, next_pc);
            checkOutput("one_outstanding", mem_busy, 1'b0);
            mem_busy  = 1'b1;
            mem_stale = 1'b0;
            mem_cnt   = lat - 1;
            mem_addr  = imem_addr;
            expQ.push_back('{instr: memWord(next_pc), pcp4: next_pc + 32'd4});
            next_pc = next_pc + 32'd4;
        end
        if (redirect) begin
            expQ.delete();
            next_pc = br ? bt : jt;
            if (mem_busy) mem_stale = 1'b1;
        end
        edge_stalld   = sd;
        edge_redirect = redirect;
    endtask

    // Monitor: compares the IF/ID register after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                checkOutput("rst_validd", ValidD, 1'b0);
                checkOutput("rst_instrd", InstrD, TB_NOP);
                checkOutput("rst_pcplus4d", PCPlus4D, 32'h0);
                model_valid = 1'b0;
                model_instr = TB_NOP;
                model_pcp4  = '0;
            end else if (edge_redirect) begin
                checkOutput("flush_validd", ValidD, 1'b0);
                checkOutput("flush_instrd", InstrD, TB_NOP);
                model_valid = 1'b0;
                model_instr = TB_NOP;
            end else if (edge_stalld) begin
                checkOutput("hold_validd", ValidD, model_valid);
                checkOutput("hold_instrd", InstrD, model_instr);
                if (model_valid) checkOutput("hold_pcplus4d", PCPlus4D, model_pcp4);
            end else if (ValidD) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_delivery", ValidD, 1'b0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("deliver_instrd", InstrD, e.instr);
                    checkOutput("deliver_pcplus4d", PCPlus4D, e.pcp4);
                    model_valid = 1'b1;
                    model_instr = e.instr;
                    model_pcp4  = e.pcp4;
                    n_deliv++;
                end
            end else begin
                checkOutput("bubble_instrd", InstrD, TB_NOP);
                model_valid = 1'b0;
                model_instr = TB_NOP;
            end
        end
    end

    initial begin
        bit req;
        bit found;
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
        PCBranchD = '0; PCJumpD = '0; imem_valid = 1'b0; imem_rdata = '0;

        // Reset, then latency-1 streaming with the first request on the first edge.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, req);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, req);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, req);
        checkOutput("first_req_after_reset", req, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, req);

        // Latency 3.
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, req);

        // Decode stall across a response.
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, (i % 5 == 2) || (i % 5 == 3), 0, 0, 0, 0, 1, req);

        // Branch to 0x100 while a latency-3 fetch is outstanding.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, req);
            found = req;
        end
        checkOutput("req_seen_before_branch", found, 1'b1);
        applyStimulus(0, 0, 0, 1, 0, 32'h0000_0100, 0, 3, req);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, req);

        // Branch and jump together pick the branch; stalled branch ignored; wrap.
        applyStimulus(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0000_0200, 1, req);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 32'h0000_0300, 0, 1, req);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, req);

        // Reset mid-WAIT with a late response arriving after release.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, req);
            found = req;
        end
        checkOutput("req_seen_before_reset", found, 1'b1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, req);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, req);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, req);

        // Randomized mix of stalls, redirects and latencies.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(0,
                          $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 25,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 6,
                          pickTarget(), pickTarget(),
                          $urandom_range(1, 3), req);
        end

        // Drain: stop issuing and let any outstanding fetch reach IF/ID.
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, req);
        checkOutput("drain_queue_empty", expQ.size(), 0);
        checkOutput("enough_deliveries", n_deliv > 100, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
